// File: rtl/fusion_sequencer.sv
// fusion_sequencer: breaks one 2/4/8 x 2/4/8-bit multiply (each operand
// signed or unsigned) into 2-bit slice pairs, issues one pair per cycle to an
// external bitbrick, and shift-adds the 6-bit signed partial products into a
// 16-bit two's-complement result.
module fusion_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [1:0]  a_bits,
    input  logic [1:0]  b_bits,
    input  logic        a_signed,
    input  logic        b_signed,
    output logic [1:0]  bb_x,
    output logic [1:0]  bb_y,
    output logic        bb_sign_x,
    output logic        bb_sign_y,
    input  logic [5:0]  bb_p,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state_q, state_d;

    // Captured operation (valid while busy)
    logic [7:0] a_q, b_q;
    logic [1:0] la_q, lb_q;          // index of the top slice of A / B
    logic       sa_q, sb_q;

    // Indices of the pair currently on the bitbrick inputs
    logic [1:0] cur_i, cur_j;

    // Shift tag pipeline that follows each issued pair to its product
    logic       vld_p0, vld_p1;
    logic [2:0] sh_p0, sh_p1;        // slice weight i+j; bit shift is 2*(i+j)

    logic signed [15:0] acc;
    logic signed [15:0] acc_sum;
    logic [15:0]        result_q;

    // Next-state decode outputs
    logic       issue, finish, accept;
    logic [1:0] pi, pj;

    // Operand sources: live inputs in the accepting cycle, captured copies after
    logic [7:0] src_a, src_b;
    logic [1:0] src_la, src_lb;
    logic       src_sa, src_sb;

    function automatic logic [1:0] last_idx(input logic [1:0] bits);
        case (bits)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] slice(input logic [7:0] v, input logic [1:0] idx);
        return v[{idx, 1'b0} +: 2];
    endfunction

    // Sign-extend a bitbrick product and place it at its slice weight
    function automatic logic signed [15:0] align_product(input logic [5:0] p, input logic [2:0] w);
        logic signed [15:0] ext;
        ext = {{10{p[5]}}, p};
        return ext <<< {w, 1'b0};
    endfunction

    assign src_a  = (state_q == IDLE) ? a                  : a_q;
    assign src_b  = (state_q == IDLE) ? b                  : b_q;
    assign src_la = (state_q == IDLE) ? last_idx(a_bits)   : la_q;
    assign src_lb = (state_q == IDLE) ? last_idx(b_bits)   : lb_q;
    assign src_sa = (state_q == IDLE) ? a_signed           : sa_q;
    assign src_sb = (state_q == IDLE) ? b_signed           : sb_q;

    assign acc_sum = acc + (vld_p1 ? align_product(bb_p, sh_p1) : 16'sd0);

    // Next-state logic: walk the i/j slice loops, then drain the product pipe
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        finish  = 1'b0;
        accept  = 1'b0;
        pi      = cur_i;
        pj      = cur_j;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    issue   = 1'b1;
                    pi      = 2'd0;
                    pj      = 2'd0;
                    state_d = (src_la == 2'd0 && src_lb == 2'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (cur_j == lb_q) begin
                    pj = 2'd0;
                    pi = cur_i + 2'd1;
                end else begin
                    pj = cur_j + 2'd1;
                end
                if (pi == la_q && pj == lb_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last product is being added when only stage 1 still holds a tag
                if (vld_p1 && !vld_p0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand capture at start acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            la_q <= '0;
            lb_q <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            la_q <= last_idx(a_bits);
            lb_q <= last_idx(b_bits);
            sa_q <= a_signed;
            sb_q <= b_signed;
        end
    end

    // Stage p0: drive the slice pair and launch its weight tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bb_x      <= '0;
            bb_y      <= '0;
            bb_sign_x <= 1'b0;
            bb_sign_y <= 1'b0;
            cur_i     <= '0;
            cur_j     <= '0;
            vld_p0    <= 1'b0;
            sh_p0     <= '0;
        end else begin
            bb_x      <= issue ? slice(src_a, pi) : 2'd0;
            bb_y      <= issue ? slice(src_b, pj) : 2'd0;
            bb_sign_x <= issue & src_sa & (pi == src_la);
            bb_sign_y <= issue & src_sb & (pj == src_lb);
            cur_i     <= pi;
            cur_j     <= pj;
            vld_p0    <= issue;
            sh_p0     <= {1'b0, pi} + {1'b0, pj};
        end
    end

    // Stage p1: tag aligned with the product the bitbrick is computing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            sh_p1  <= '0;
        end else begin
            vld_p1 <= vld_p0;
            sh_p1  <= sh_p0;
        end
    end

    // Accumulate returned products; publish result and pulse done on the last add
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            result_q <= '0;
            done     <= 1'b0;
        end else begin
            acc  <= accept ? 16'sd0 : acc_sum;
            done <= finish;
            if (finish) result_q <= acc_sum;
        end
    end

    assign busy   = (state_q != IDLE);
    assign result = result_q;

endmodule

// File: tb/tb_fusion_sequencer.sv
// Bench for fusion_sequencer: a behavioural bitbrick drives bb_p, and every
// operation is checked cycle by cycle against slice order and a plain
// integer product computed from the operands.
module tb_fusion_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  a, b;
    logic [1:0]  a_bits, b_bits;
    logic        a_signed, b_signed;
    logic [1:0]  bb_x, bb_y;
    logic        bb_sign_x, bb_sign_y;
    logic [5:0]  bb_p;
    logic        busy, done;
    logic [15:0] result;

    int total  = 0;
    int passed = 0;

    fusion_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .a_bits(a_bits), .b_bits(b_bits), .a_signed(a_signed), .b_signed(b_signed),
        .bb_x(bb_x), .bb_y(bb_y), .bb_sign_x(bb_sign_x), .bb_sign_y(bb_sign_y),
        .bb_p(bb_p), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Bitbrick model: registered signed/unsigned 2x2 product
    int xv, yv;
    always_comb begin
        xv = int'(bb_x);
        yv = int'(bb_y);
        if (bb_sign_x && bb_x[1]) xv = xv - 4;
        if (bb_sign_y && bb_y[1]) yv = yv - 4;
    end
    always @(posedge clk or negedge reset) begin
        if (!reset) bb_p <= '0;
        else        bb_p <= 6'(xv * yv);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int width_of(input logic [1:0] bits);
        return (bits == 2'b00) ? 2 : (bits == 2'b01) ? 4 : 8;
    endfunction

    function automatic int opval(input logic [7:0] v, input logic [1:0] bits, input logic s);
        int w = width_of(bits);
        int r = int'(v) & ((1 << w) - 1);
        if (s && ((r >> (w - 1)) & 1) == 1) r = r - (1 << w);
        return r;
    endfunction

    function automatic logic [15:0] ref_mul(input logic [7:0] av, input logic [7:0] bv,
                                             input logic [1:0] ab, input logic [1:0] bbits,
                                             input logic as_, input logic bs_);
        return 16'(opval(av, ab, as_) * opval(bv, bbits, bs_));
    endfunction

    // Called at a negedge; start is raised so the next posedge is E0.
    task automatic run(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] ab,
                       input logic [1:0] bbits, input logic as_, input logic bs_,
                       input bit hold, input bit pulse_mid);
        int na = width_of(ab) / 2;
        int nb = width_of(bbits) / 2;
        int n_pairs = na * nb;
        logic [15:0] exp_res = ref_mul(av, bv, ab, bbits, as_, bs_);
        a = av; b = bv; a_bits = ab; b_bits = bbits; a_signed = as_; b_signed = bs_;
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < n_pairs; n++) begin
            int i = n / nb;
            int j = n % nb;
            @(negedge clk);
            if (n == 0 && !hold) start = 1'b0;
            chk("bb_x",      bb_x,      16'((int'(av) >> (2 * i)) & 3));
            chk("bb_y",      bb_y,      16'((int'(bv) >> (2 * j)) & 3));
            chk("bb_sign_x", bb_sign_x, 16'(as_ && i == na - 1));
            chk("bb_sign_y", bb_sign_y, 16'(bs_ && j == nb - 1));
            chk("busy_issue", busy, 16'd1);
            chk("done_early", done, 16'd0);
            if (pulse_mid && n == 2) begin
                start = 1'b1; a = ~av; b = ~bv; a_bits = 2'b00; a_signed = ~as_;
            end
            if (pulse_mid && n == 3) start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk("busy_drain", busy, 16'd1);
        chk("done_drain", done, 16'd0);
        chk("bb_x_drain", bb_x, 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", done, 16'd1);
        chk("busy_end",   busy, 16'd0);
        chk("result",     result, exp_res);
        chk("bb_idle",    {bb_x, bb_y, bb_sign_x, bb_sign_y}, 16'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        a_bits = '0; b_bits = '0; a_signed = 1'b0; b_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   busy, 16'd0);
        chk("rst_done",   done, 16'd0);
        chk("rst_result", result, 16'd0);
        chk("rst_bb",     {bb_x, bb_y, bb_sign_x, bb_sign_y}, 16'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        run(8'd3,   8'd3,   2'b00, 2'b00, 1'b0, 1'b0, 0, 0);  // 0x0009
        chk("r_2x2", result, 16'h0009);
        run(8'h80,  8'h80,  2'b10, 2'b10, 1'b1, 1'b1, 0, 0);  // 0x4000
        chk("r_s8x8", result, 16'h4000);
        run(8'hFB,  8'd200, 2'b01, 2'b10, 1'b1, 1'b0, 0, 0);  // -1000
        chk("r_4x8", result, 16'hFC18);
        run(8'hFF,  8'hFF,  2'b10, 2'b11, 1'b0, 1'b0, 0, 0);  // 0xFE01
        chk("r_u8x8", result, 16'hFE01);
        run(8'h80,  8'hFF,  2'b10, 2'b10, 1'b1, 1'b0, 0, 0);  // 0x8080
        chk("r_su", result, 16'h8080);

        // Start pulsed mid-operation with changed inputs is ignored
        run(8'h5A,  8'hC3,  2'b10, 2'b10, 1'b1, 1'b0, 0, 1);
        // Start held through done: back-to-back acceptance in the done cycle
        run(8'h7F,  8'h81,  2'b10, 2'b10, 1'b1, 1'b1, 1, 0);
        run(8'h0D,  8'h96,  2'b01, 2'b10, 1'b0, 1'b1, 0, 0);

        // Randomized operations
        for (int k = 0; k < 24; k++) begin
            run(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 0, 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Asynchronous reset in the middle of ISSUE
        a = 8'hA5; b = 8'h3C; a_bits = 2'b10; b_bits = 2'b10; a_signed = 1'b1; b_signed = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy",   busy, 16'd0);
        chk("arst_done",   done, 16'd0);
        chk("arst_result", result, 16'd0);
        chk("arst_bb",     {bb_x, bb_y, bb_sign_x, bb_sign_y}, 16'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) reset = 1'b1;
            chk("arst_no_done", done, 16'd0);
        end
        chk("arst_result_hold", result, 16'd0);
        run(8'd2, 8'd3, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0);
        chk("r_after_rst", result, 16'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fusion_sequencer.md
# fusion_sequencer

Sequential Fusion Unit front-end that drives a single `bitbrick` over its operand/product interface. It accepts one 2/4/8-bit × 2/4/8-bit multiply (each operand independently signed or unsigned), decomposes the operands into 2-bit slices, and issues slice pairs to the bitbrick one per cycle. It shift-adds the returned 6-bit partial products into a 16-bit result. This block sits between the PE operand registers and one bitbrick instance. It is the initiator side of the bitbrick interface.

## Interface
- No parameters. Widths are fixed: 8-bit operands, 16-bit result.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-low. Clears all state.
- `start` in 1 — request. Sampled only when `busy`=0.
- `a` in 8 — operand A, LSB-aligned.
- `b` in 8 — operand B, LSB-aligned.
- `a_bits` in 2 — A precision: 00=2, 01=4, 10=8, 11 treated as 8.
- `b_bits` in 2 — B precision, same encoding as `a_bits`.
- `a_signed` in 1 — A is two's complement.
- `b_signed` in 1 — B is two's complement.
- `bb_x` out 2 — slice of A to the bitbrick. Registered.
- `bb_y` out 2 — slice of B to the bitbrick. Registered.
- `bb_sign_x` out 1 — `bb_x` is the signed top slice. Registered.
- `bb_sign_y` out 1 — `bb_y` is the signed top slice. Registered.
- `bb_p` in 6 — bitbrick product, interpreted as signed 6-bit. Valid one edge after the bitbrick samples its inputs.
- `busy` out 1 — operation in flight.
- `done` out 1 — one-cycle pulse; `result` is valid while it is high.
- `result` out 16 — two's-complement product. Holds until the next accepted `start`.

## Operation
- Slice counts: Na = bits(A)/2 and Nb = bits(B)/2. Total issue count N = Na·Nb, which is 1, 2, 4, 8 or 16.
- Issue order: outer loop i = 0..Na-1, inner loop j = 0..Nb-1.
- Per-pair drive values:
  - `bb_x` = A[2i+1:2i] and `bb_y` = B[2j+1:2j].
  - `bb_sign_x` = `a_signed` & (i == Na-1).
  - `bb_sign_y` = `b_signed` & (j == Nb-1).
- Bits of A/B above the selected precision are ignored.
- Accumulation: acc += sext16(`bb_p`) << 2(i+j), modulo 2^16.
  - The shift amount travels with each issued pair through a 2-stage delay pipe.
  - The result is exact for every mode. If either operand is signed, `result` is read as signed.
- Operands, precisions and signedness are captured at start acceptance. Input changes during `busy` have no effect.
- FSM states:
  - IDLE: `busy`=0. `start`=1 → capture operands, drive pair 0, clear acc, go to ISSUE.
  - ISSUE: drive pairs 1..N-1 on successive edges, then go to DRAIN. For N=1, go straight to DRAIN.
  - DRAIN: wait for the final two products to accumulate. Then update `result`, pulse `done`, go to IDLE.
- `start` while `busy`=1 is ignored (not queued).
- `start` in the cycle `done` is high is accepted; that cycle is IDLE.

## Timing
- Label the accepting edge E0. Pair n is driven from edge En.
- Product of pair n is on `bb_p` after E(n+1) and is added to acc at E(n+2).
- Last add is at E(N+1). At that edge `result` is loaded, `done`=1 for one cycle, and `busy` falls.
  - `busy` is high from E0 to E(N+1).
  - Start-to-done latency is N+1 edges: 2×2 → E2, 8×8 → E17.
- After `done`, `bb_*` outputs return to 0.
- Reset values (immediate, asynchronous): state IDLE; `busy`, `done`, `result`, `bb_x`, `bb_y`, `bb_sign_x`, `bb_sign_y`, acc and the delay pipe all 0.
- Reset asserted mid-operation aborts the operation: no `done` pulse, and `result` reads 0.
- The first `start` after reset release is accepted normally.
- The attached bitbrick shares `clk` and is reset in the same domain. Its reset `bb_p` value (0) is never accumulated, because acc adds only at tagged pipe stages.

## Test plan
- 2×2 unsigned: a=3, b=3, start at E0 → `bb_x`=3, `bb_y`=3; `done` at E2 with `result`=0x0009; `busy` high for 2 cycles.
- 8×8 signed: a=0x80, b=0x80 → 16 pairs issued in i/j order, with `bb_sign_x`=1 only when i=3 and `bb_sign_y`=1 only when j=3; `done` at E17, `result`=0x4000.
- Mixed 4×8: a=4'b1011 signed, b=200 unsigned, a[7:4]=0xF as garbage → N=8; `done` at E9, `result`=0xFC18 (−1000).
- Unsigned 8×8 extreme: a=0xFF, b=0xFF → `result`=0xFE01. Signed×unsigned: a=0x80 signed, b=0xFF unsigned → `result`=0x8080.
- Handshake: `start` pulsed again at E3 of a 16-pair op → ignored. `start` held high through `done` → second op accepted in the `done` cycle, second `done` 17 edges later.
- Async reset: `reset` low mid-ISSUE between edges → `busy`, `done`, `result` and all `bb_*` go to 0 immediately; no `done` pulse. After release, a=2, b=3 (2-bit unsigned) → `result`=6 at E2.
